// File: rtl/pattern_pkg.sv
// Shared constants for the test-pattern frame writer: pattern modes, FSM
// states and the colour-bar table.
package pattern_pkg;

  localparam logic [2:0] MODE_WHITE = 3'd0;
  localparam logic [2:0] MODE_SPLIT = 3'd1;
  localparam logic [2:0] MODE_BARS  = 3'd2;
  localparam logic [2:0] MODE_CHECK = 3'd3;
  localparam logic [2:0] MODE_RAMP  = 3'd4;
  localparam logic [2:0] MODE_GREY  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Bar colours as {R,G,B} on/off flags, left to right.
  function automatic logic [2:0] bar_flags(input logic [2:0] idx);
    logic [2:0] f;
    case (idx)
      3'd0:    f = 3'b111;
      3'd1:    f = 3'b110;
      3'd2:    f = 3'b011;
      3'd3:    f = 3'b010;
      3'd4:    f = 3'b101;
      3'd5:    f = 3'b100;
      3'd6:    f = 3'b001;
      default: f = 3'b000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/pattern_pixel_gen.sv
// Combinational colour of one pixel for the selected pattern mode.
module pattern_pixel_gen
  import pattern_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned BPC        = 8,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter int unsigned XPW        = 10
) (
  input  logic [2:0]       mode_i,
  input  logic [XPW-1:0]   x_i,
  input  logic             y_chk_i,
  input  logic [2:0]       bar_i,
  input  logic [7:0]       frame_cnt_i,
  output logic [3*BPC-1:0] pix_o
);

  logic [BPC-1:0] grey;
  logic [BPC-1:0] ramp;
  logic [2:0]     bar_f;

  // Grey level keeps the MSBs of the frame count when components are narrow.
  if (BPC >= 8) begin : g_grey_wide
    assign grey = BPC'(frame_cnt_i);
  end else begin : g_grey_narrow
    assign grey = frame_cnt_i[7 -: BPC];
  end

  assign ramp  = BPC'(x_i);
  assign bar_f = bar_flags(bar_i);

  always_comb begin
    pix_o = '0;
    case (mode_i)
      MODE_WHITE: pix_o = '1;
      MODE_SPLIT: pix_o = (x_i < XPW'(H_ACTIVE / 2)) ? '1 : {{BPC{1'b1}}, {(2*BPC){1'b0}}};
      MODE_BARS:  pix_o = {{BPC{bar_f[2]}}, {BPC{bar_f[1]}}, {BPC{bar_f[0]}}};
      MODE_CHECK: pix_o = (x_i[CHECK_LOG2] ^ y_chk_i) ? '1 : '0;
      MODE_RAMP:  pix_o = {ramp, ramp, ramp};
      MODE_GREY:  pix_o = {grey, grey, grey};
      default:    pix_o = '0;
    endcase
  end

endmodule

// File: rtl/pattern_frame_writer.sv
// Test-pattern generator filling the frame memory one packed word at a time
// through a valid/ready write port.
module pattern_frame_writer
  import pattern_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned PIX_PER_WORD = 2,
  parameter int unsigned BPC          = 8,
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned CHECK_LOG2   = 5
) (
  input  logic                            clk24,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [2:0]                      mode,
  output logic                            wr_valid,
  input  logic                            wr_ready,
  output logic [ADDR_W-1:0]               wr_addr,
  output logic [PIX_PER_WORD*3*BPC-1:0]   wr_data,
  output logic                            frame_done,
  output logic                            busy,
  output logic [7:0]                      frame_cnt
);

  localparam int unsigned WPL   = H_ACTIVE / PIX_PER_WORD;
  localparam int unsigned WORDS = WPL * V_ACTIVE;
  localparam int unsigned WPB   = WPL / 8;
  localparam int unsigned PIX_W = 3 * BPC;
  localparam int unsigned DW    = PIX_PER_WORD * PIX_W;
  localparam int unsigned XWW   = $clog2(WPL);
  localparam int unsigned YW    = $clog2(V_ACTIVE);
  localparam int unsigned BCW   = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int unsigned XPW   = $clog2(H_ACTIVE);

  state_e            state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [XWW-1:0]    xw_q, xw_d;
  logic [YW-1:0]     y_q, y_d;
  logic [2:0]        bar_q, bar_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d, gen_data;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic              xfer, start, load;

  assign xfer = valid_q & wr_ready;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    xw_d    = xw_q;
    y_d     = y_q;
    bar_d   = bar_q;
    bcnt_d  = bcnt_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;
    start   = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: start = enable;
      ST_RUN: begin
        if (xfer) begin
          load = 1'b1;
          if (addr_q == ADDR_W'(WORDS - 1)) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            fcnt_d  = fcnt_q + 8'd1;
            xw_d    = '0;
            y_d     = '0;
            bar_d   = '0;
            bcnt_d  = '0;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (xw_q == XWW'(WPL - 1)) begin
              xw_d   = '0;
              y_d    = y_q + YW'(1);
              bar_d  = '0;
              bcnt_d = '0;
            end else begin
              xw_d = xw_q + XWW'(1);
              if (bcnt_q == BCW'(WPB - 1)) begin
                bcnt_d = '0;
                bar_d  = bar_q + 3'd1;
              end else begin
                bcnt_d = bcnt_q + BCW'(1);
              end
            end
          end
        end
      end
      ST_DONE: begin
        start = enable;
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = ST_RUN;
      mode_d  = mode;
      xw_d    = '0;
      y_d     = '0;
      bar_d   = '0;
      bcnt_d  = '0;
      addr_d  = '0;
      valid_d = 1'b1;
      load    = 1'b1;
    end
    busy_d = (state_d == ST_RUN);
    // Data is generated from the next-state counters so the registered word
    // always matches the registered address.
    data_d = load ? gen_data : data_q;
  end

  for (genvar p = 0; p < PIX_PER_WORD; p++) begin : g_pix
    logic [XPW-1:0] x_p;
    assign x_p = XPW'(xw_d) * XPW'(PIX_PER_WORD) + XPW'(p);
    pattern_pixel_gen #(
      .H_ACTIVE  (H_ACTIVE),
      .BPC       (BPC),
      .CHECK_LOG2(CHECK_LOG2),
      .XPW       (XPW)
    ) u_pix (
      .mode_i     (mode_d),
      .x_i        (x_p),
      .y_chk_i    (y_d[CHECK_LOG2]),
      .bar_i      (bar_d),
      .frame_cnt_i(fcnt_d),
      .pix_o      (gen_data[p*PIX_W +: PIX_W])
    );
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      xw_q    <= '0;
      y_q     <= '0;
      bar_q   <= '0;
      bcnt_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      xw_q    <= xw_d;
      y_q     <= y_d;
      bar_q   <= bar_d;
      bcnt_q  <= bcnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign wr_valid   = valid_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign frame_done = done_q;
  assign busy       = busy_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_pattern_frame_writer.sv
// Randomised bench for pattern_frame_writer against a frame-level reference
// model, using a reduced 64x8 resolution to keep runs short.
module tb_pattern_frame_writer;

  localparam int unsigned H     = 64;
  localparam int unsigned V     = 8;
  localparam int unsigned PPW   = 2;
  localparam int unsigned CL    = 2;
  localparam int unsigned AW    = 8;
  localparam int unsigned WPL   = H / PPW;
  localparam int unsigned WORDS = WPL * V;
  localparam int unsigned DW    = PPW * 24;

  logic          clk24 = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic          wr_ready = 1'b1;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_done;
  logic          busy;
  logic [7:0]    frame_cnt;

  int checks = 0;
  int errors = 0;
  int test = 0;
  bit rand_ready = 0;
  bit rand_mode = 0;

  pattern_frame_writer #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .PIX_PER_WORD(PPW),
    .BPC         (8),
    .ADDR_W      (AW),
    .CHECK_LOG2  (CL)
  ) dut (
    .clk24     (clk24),
    .rst_n     (rst_n),
    .enable    (enable),
    .mode      (mode),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_done(frame_done),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk24 = ~clk24;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] bar_col(input int unsigned b);
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [2:0] md, input int unsigned a,
                                             input logic [7:0] fc);
    int unsigned xw = a % WPL;
    int unsigned y = a / WPL;
    logic [DW-1:0] w = '0;
    for (int p = 0; p < PPW; p++) begin
      int unsigned x = xw * PPW + p;
      logic [23:0] px;
      case (md)
        3'd0: px = 24'hFFFFFF;
        3'd1: px = (x < H / 2) ? 24'hFFFFFF : 24'hFF0000;
        3'd2: px = bar_col(x / (H / 8));
        3'd3: px = ((((x >> CL) ^ (y >> CL)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
        3'd4: px = {3{8'(x)}};
        3'd5: px = {3{fc}};
        default: px = 24'h000000;
      endcase
      w[p*24 +: 24] = px;
    end
    return w;
  endfunction

  // Frame-level reference: a frame is in flight from the edge that sees
  // enable while not in flight, until the last word is accepted.
  bit          m_active = 0;
  bit          m_done = 0;
  int unsigned m_addr = 0;
  logic [2:0]  m_mode = 3'd0;
  logic [7:0]  m_fcnt = 8'd0;

  always @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0;
      m_done   <= 0;
      m_addr   <= 0;
      m_mode   <= 3'd0;
      m_fcnt   <= 8'd0;
    end else if (m_active) begin
      m_done <= 0;
      if (wr_ready) begin
        if (m_addr == WORDS - 1) begin
          m_active <= 0;
          m_done   <= 1;
          m_fcnt   <= m_fcnt + 8'd1;
        end else begin
          m_addr <= m_addr + 1;
        end
      end
    end else begin
      m_done <= 0;
      if (enable) begin
        m_active <= 1;
        m_addr   <= 0;
        m_mode   <= mode;
      end
    end
  end

  bit t1_on = 0;
  bit t1_done = 0;
  int t1_n = 0;

  always @(negedge clk24) begin
    if (!rst_n) begin
      chk("rst_valid", wr_valid, 0);
      chk("rst_addr", wr_addr, 0);
      chk("rst_data", wr_data, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fcnt", frame_cnt, 0);
    end else begin
      chk("valid", wr_valid, m_active);
      chk("busy", busy, m_active);
      chk("frame_done", frame_done, m_done);
      chk("frame_cnt", frame_cnt, m_fcnt);
      if (m_active) begin
        chk("addr", wr_addr, m_addr);
        chk("data", wr_data, exp_word(m_mode, m_addr, m_fcnt));
        if (test == 1 && m_addr == 0)  chk("lit_split_w0", wr_data, 48'hFFFFFFFFFFFF);
        if (test == 1 && m_addr == 16) chk("lit_split_w16", wr_data, 48'hFF0000FF0000);
        if (test == 2 && m_addr == 4)  chk("lit_bar_yellow", wr_data, 48'hFFFF00FFFF00);
        if (test == 2 && m_addr == 28) chk("lit_bar_black", wr_data, 48'h0);
        if (test == 2 && m_addr == 32) chk("lit_bar_line1", wr_data, 48'hFFFFFFFFFFFF);
        if (test == 3 && m_addr == 5)  chk("lit_ramp_w5", wr_data, 48'h0B0B0B0A0A0A);
        if (test == 3 && m_addr == 37) chk("lit_ramp_w37", wr_data, 48'h0B0B0B0A0A0A);
        if (test == 4 && m_addr == 0)  chk("lit_chk_w0", wr_data, 48'h0);
        if (test == 4 && m_addr == 2)  chk("lit_chk_w2", wr_data, 48'hFFFFFFFFFFFF);
        if (test == 4 && m_addr == 128) chk("lit_chk_w128", wr_data, 48'hFFFFFFFFFFFF);
      end
      if (test == 1) begin
        if (!t1_on && wr_valid) begin
          t1_on = 1;
          t1_n = 1;
        end else if (t1_on && !t1_done) begin
          t1_n++;
        end
        if (t1_on && !t1_done && frame_done) begin
          t1_done = 1;
          chk("done_latency", t1_n, 257);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk24);
    #1;
    if (rand_ready) wr_ready = ($urandom_range(0, 1) == 1);
    if (rand_mode) mode = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (frame_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("frame_timeout", (n < budget), 1);
  endtask

  task automatic one_frame(input logic [2:0] md, input int budget);
    mode = md;
    enable = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    wait_done(budget);
    repeat (2) tick();
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    test = 1;
    one_frame(3'd1, 2000);
    chk("t1_idle_busy", busy, 0);
    chk("t1_fcnt", frame_cnt, 1);

    test = 2;
    one_frame(3'd2, 2000);

    test = 3;
    rand_ready = 1;
    one_frame(3'd4, 4000);
    rand_ready = 0;
    wr_ready = 1'b1;

    test = 4;
    one_frame(3'd3, 2000);

    // Back-to-back grey frames from a fresh reset.
    test = 5;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    mode = 3'd5;
    enable = 1'b1;
    wait_done(2000);
    tick();
    wait_done(2000);
    tick();
    repeat (20) tick();
    enable = 1'b0;
    wait_done(2000);
    repeat (2) tick();
    chk("t5_fcnt", frame_cnt, 3);
    chk("t5_busy", busy, 0);
    chk("t5_valid", wr_valid, 0);

    // Random mode every cycle and random backpressure across frames.
    test = 6;
    rand_ready = 1;
    rand_mode = 1;
    enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_done(4000);
      if (f == 2) enable = 1'b0;
      tick();
    end
    rand_ready = 0;
    rand_mode = 0;
    wr_ready = 1'b1;
    repeat (3) tick();

    // Asynchronous reset in the middle of a frame.
    test = 7;
    mode = 3'd0;
    enable = 1'b1;
    begin
      int n = 0;
      while (wr_addr !== AW'(100) && n < 1000) begin
        tick();
        n++;
      end
      chk("t7_reach_timeout", (n < 1000), 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_valid0", wr_valid, 0);
    chk("t7_addr0", wr_addr, 0);
    chk("t7_data0", wr_data, 0);
    chk("t7_busy0", busy, 0);
    chk("t7_fcnt0", frame_cnt, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t7_restart_valid", wr_valid, 1);
    chk("t7_restart_addr", wr_addr, 0);
    enable = 1'b0;
    wait_done(2000);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
